// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port data memory arbiter: memory status codes,
// arbiter FSM states and port identifiers.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'b00,
    MEM_BUSY = 2'b01,
    MEM_DONE = 2'b10
  } mem_status_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    BUSY,
    RESP
  } arb_state_e;

  typedef enum logic {
    PORT_D = 1'b0,
    PORT_I = 1'b1
  } port_e;

  function automatic port_e other_port(input port_e p);
    return (p == PORT_D) ? PORT_I : PORT_D;
  endfunction

endpackage

// File: rtl/mem_arbiter_arb_select.sv
// Combinational two-way picker: fixed D-over-I priority, or alternation
// against the previous grant when both ports contend.
module arb_select
  import mem_arb_pkg::*;
#(
  parameter int unsigned ROUND_ROBIN = 0
) (
  input  logic  d_req,
  input  logic  i_req,
  input  port_e last_grant,
  output logic  gnt_valid,
  output port_e gnt_port
);

  always_comb begin
    gnt_valid = d_req | i_req;
    gnt_port  = PORT_I;
    if (d_req && i_req) begin
      gnt_port = (ROUND_ROBIN != 0) ? other_port(last_grant) : PORT_D;
    end else if (d_req) begin
      gnt_port = PORT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-ported multi-cycle data memory between instruction fetch
// (port I) and the memory stage (port D), one transaction at a time.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ROUND_ROBIN = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        i_done,
  output logic [31:0] i_rdata,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  mem_status
);

  arb_state_e  state_q, state_d;
  port_e       grant_q, grant_d;
  logic        grant_vld_q, grant_vld_d;
  port_e       last_grant_q, last_grant_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic        d_done_q, d_done_d;
  logic        i_done_q, i_done_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic [31:0] i_rdata_q, i_rdata_d;

  logic        sel_valid;
  port_e       sel_port;
  mem_status_e status;

  assign status = mem_status_e'(mem_status);

  arb_select #(
    .ROUND_ROBIN(ROUND_ROBIN)
  ) u_select (
    .d_req     (d_req),
    .i_req     (i_req),
    .last_grant(last_grant_q),
    .gnt_valid (sel_valid),
    .gnt_port  (sel_port)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    grant_vld_d  = grant_vld_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    d_done_d     = 1'b0;
    i_done_d     = 1'b0;
    d_rdata_d    = d_rdata_q;
    i_rdata_d    = i_rdata_q;

    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          state_d      = ISSUE;
          grant_d      = sel_port;
          grant_vld_d  = 1'b1;
          last_grant_d = sel_port;
          if (sel_port == PORT_D) begin
            addr_d  = d_addr;
            we_d    = d_we;
            wdata_d = d_wdata;
          end else begin
            addr_d  = i_addr;
            we_d    = i_we;
            wdata_d = i_wdata;
          end
        end
      end
      // Enter BUSY only at the start of a fresh memory cycle.
      ISSUE: begin
        if (status == MEM_IDLE) state_d = BUSY;
      end
      // Done and rdata are loaded here so they appear registered in RESP.
      BUSY: begin
        if (status == MEM_DONE) begin
          state_d = RESP;
          if (grant_vld_q && grant_q == PORT_D) begin
            d_done_d = 1'b1;
            if (!we_q) d_rdata_d = mem_rdata;
          end else if (grant_vld_q) begin
            i_done_d = 1'b1;
            if (!we_q) i_rdata_d = mem_rdata;
          end
        end
      end
      RESP: begin
        state_d     = IDLE;
        grant_vld_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= PORT_I;
      grant_vld_q  <= 1'b0;
      last_grant_q <= PORT_I;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      d_done_q     <= 1'b0;
      i_done_q     <= 1'b0;
      d_rdata_q    <= '0;
      i_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      grant_vld_q  <= grant_vld_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      d_done_q     <= d_done_d;
      i_done_q     <= i_done_d;
      d_rdata_q    <= d_rdata_d;
      i_rdata_q    <= i_rdata_d;
    end
  end

  // The memory writes whenever write-enable is high, so it is confined to BUSY.
  assign mem_valid = (state_q == ISSUE) || (state_q == BUSY);
  assign mem_we    = we_q && (state_q == BUSY);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign d_done    = d_done_q;
  assign i_done    = i_done_q;
  assign d_rdata   = d_rdata_q;
  assign i_rdata   = i_rdata_q;

endmodule
